// File: rtl/intr_pkg.sv
// intr_pkg: shared definitions for the interrupt controller.
//   - MMIO register offsets relative to the block base address
//   - sequencing FSM state encoding
//   - ID field width and the lowest-index-wins priority encoder
package intr_pkg;

    localparam int ID_W = 5;

    localparam logic [31:0] PEND_OFS = 32'h0000_0000;
    localparam logic [31:0] MASK_OFS = 32'h0000_0004;
    localparam logic [31:0] ID_OFS   = 32'h0000_0008;
    localparam logic [31:0] CTRL_OFS = 32'h0000_000C;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ASSERT = 2'd1,
        ST_WAIT   = 2'd2,
        ST_COOL   = 2'd3
    } state_t;

    // Lowest set bit wins; scanning downward lets the lowest index overwrite.
    function automatic logic [ID_W-1:0] prio_enc(input logic [31:0] vec);
        logic [ID_W-1:0] idx;
        idx = {ID_W{1'b0}};
        for (int i = 31; i >= 0; i--) begin
            if (vec[i]) begin
                idx = ID_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/intr_edge_sync.sv
// intr_edge_sync: per-bit two-flop synchroniser followed by a rising-edge
// detector. A held level yields a single one-cycle pulse.
// Ports:
//   CLK    in         clock
//   RESET  in         synchronous active-high reset
//   din    in  WIDTH  asynchronous level inputs
//   rise   out WIDTH  one-cycle pulse, high the cycle after the second sync flop
//                     first sees the new level
module intr_edge_sync #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] rise
);

    logic [WIDTH-1:0] meta_r;
    logic [WIDTH-1:0] sync_r;
    logic [WIDTH-1:0] prev_r;

    // Synchroniser chain plus one delayed copy for edge detection.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            meta_r <= {WIDTH{1'b0}};
            sync_r <= {WIDTH{1'b0}};
            prev_r <= {WIDTH{1'b0}};
        end else begin
            meta_r <= din;
            sync_r <= meta_r;
            prev_r <= sync_r;
        end
    end

    assign rise = sync_r & ~prev_r;

endmodule

// File: rtl/intr_controller.sv
// intr_controller: memory-mapped interrupt controller driving the CPU INTR pin.
// Rising edges on SRC_IN latch into PEND; the lowest-index pending & masked
// source is sequenced through ASSERT (INTR high INTR_CYCLES cycles), WAIT
// (until claimed or its PEND bit is cleared) and COOL (COOLDOWN idle cycles).
// INTR_CYCLES and COOLDOWN must both be at least 1.
// Ports:
//   CLK, RESET              clock, synchronous active-high reset
//   SRC_IN     in NUM_SRC   asynchronous event levels
//   IOBUS_ADDR in 32        bus address
//   IOBUS_OUT  in 32        bus write data
//   IOBUS_WR   in 1         bus write strobe
//   RD_DATA    out 32       addressed register contents, 0 when not addressed
//   RD_HIT     out 1        address matches one of the four registers
//   INTR       out 1        registered interrupt request
module intr_controller #(
    parameter int          NUM_SRC     = 8,
    parameter logic [31:0] BASE_AD     = 32'h1100_0060,
    parameter int          INTR_CYCLES = 4,
    parameter int          COOLDOWN    = 2
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic [NUM_SRC-1:0] SRC_IN,
    input  logic [31:0]        IOBUS_ADDR,
    input  logic [31:0]        IOBUS_OUT,
    input  logic               IOBUS_WR,
    output logic [31:0]        RD_DATA,
    output logic               RD_HIT,
    output logic               INTR
);

    import intr_pkg::*;

    localparam logic [7:0] ASSERT_LAST = 8'(INTR_CYCLES - 1);
    localparam logic [7:0] COOL_LAST   = 8'(COOLDOWN - 1);

    logic [NUM_SRC-1:0] pend_r, mask_r;
    logic               en_r, valid_r, intr_r;
    logic [ID_W-1:0]    id_r, id_next_s, winner_s;
    logic               valid_next_s;
    state_t             state_r, state_next_s;
    logic [7:0]         cnt_r, cnt_next_s;

    logic [NUM_SRC-1:0] edge_s, w1c_s, served_clr_s, id_hot_s, active_s;
    logic               hit_pend_s, hit_mask_s, hit_id_s, hit_ctrl_s, claim_s;
    logic [31:0]        rd_data_s;
    logic               rd_hit_s;
    logic               unused_wdata_s;

    intr_edge_sync #(.WIDTH(NUM_SRC)) u_sync (
        .CLK   (CLK),
        .RESET (RESET),
        .din   (SRC_IN),
        .rise  (edge_s)
    );

    assign hit_pend_s = (IOBUS_ADDR == (BASE_AD + PEND_OFS));
    assign hit_mask_s = (IOBUS_ADDR == (BASE_AD + MASK_OFS));
    assign hit_id_s   = (IOBUS_ADDR == (BASE_AD + ID_OFS));
    assign hit_ctrl_s = (IOBUS_ADDR == (BASE_AD + CTRL_OFS));
    assign claim_s    = IOBUS_WR & hit_id_s;
    assign active_s   = pend_r & mask_r;
    assign winner_s   = prio_enc(32'(active_s));
    assign id_hot_s   = NUM_SRC'(1) << id_r;
    // Only part of the write word lands in registers.
    assign unused_wdata_s = ^IOBUS_OUT;

    // W1C mask for PEND from a bus write.
    always_comb begin
        w1c_s = {NUM_SRC{1'b0}};
        if (IOBUS_WR && hit_pend_s) begin
            w1c_s = IOBUS_OUT[NUM_SRC-1:0];
        end else begin
            w1c_s = {NUM_SRC{1'b0}};
        end
    end

    // Sequencer next-state: claim/clear exits, cycle counters, ID latching.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        id_next_s    = id_r;
        valid_next_s = valid_r;
        served_clr_s = {NUM_SRC{1'b0}};
        case (state_r)
            ST_IDLE: begin
                if (en_r && (|active_s)) begin
                    id_next_s    = winner_s;
                    valid_next_s = 1'b1;
                    cnt_next_s   = 8'd0;
                    state_next_s = ST_ASSERT;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ASSERT: begin
                if (claim_s) begin
                    served_clr_s = id_hot_s;
                    valid_next_s = 1'b0;
                    cnt_next_s   = 8'd0;
                    state_next_s = ST_COOL;
                end else if (cnt_r == ASSERT_LAST) begin
                    cnt_next_s   = 8'd0;
                    state_next_s = ST_WAIT;
                end else begin
                    cnt_next_s   = cnt_r + 8'd1;
                end
            end
            ST_WAIT: begin
                if (claim_s) begin
                    served_clr_s = id_hot_s;
                    valid_next_s = 1'b0;
                    cnt_next_s   = 8'd0;
                    state_next_s = ST_COOL;
                end else if ((w1c_s & id_hot_s) != {NUM_SRC{1'b0}}) begin
                    valid_next_s = 1'b0;
                    cnt_next_s   = 8'd0;
                    state_next_s = ST_COOL;
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            ST_COOL: begin
                if (cnt_r == COOL_LAST) begin
                    cnt_next_s   = 8'd0;
                    state_next_s = ST_IDLE;
                end else begin
                    cnt_next_s   = cnt_r + 8'd1;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                cnt_next_s   = 8'd0;
                valid_next_s = 1'b0;
            end
        endcase
    end

    // Sequencer state and registered INTR (high exactly while in ASSERT).
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r <= ST_IDLE;
            cnt_r   <= 8'd0;
            id_r    <= {ID_W{1'b0}};
            valid_r <= 1'b0;
            intr_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
            id_r    <= id_next_s;
            valid_r <= valid_next_s;
            intr_r  <= (state_next_s == ST_ASSERT);
        end
    end

    // Configuration and pending registers; a new edge beats a same-cycle clear.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            pend_r <= {NUM_SRC{1'b0}};
            mask_r <= {NUM_SRC{1'b0}};
            en_r   <= 1'b0;
        end else begin
            pend_r <= (pend_r & ~(w1c_s | served_clr_s)) | edge_s;
            if (IOBUS_WR && hit_mask_s) begin
                mask_r <= IOBUS_OUT[NUM_SRC-1:0];
            end
            if (IOBUS_WR && hit_ctrl_s) begin
                en_r <= IOBUS_OUT[0];
            end
        end
    end

    // Read mux; zero when unaddressed so it can be OR-ed into the bus.
    always_comb begin
        rd_data_s = 32'h0000_0000;
        rd_hit_s  = 1'b1;
        if (hit_pend_s) begin
            rd_data_s = 32'(pend_r);
        end else if (hit_mask_s) begin
            rd_data_s = 32'(mask_r);
        end else if (hit_id_s) begin
            rd_data_s = {valid_r, 26'd0, id_r};
        end else if (hit_ctrl_s) begin
            rd_data_s = {31'd0, en_r};
        end else begin
            rd_hit_s  = 1'b0;
        end
    end

    assign RD_DATA = rd_data_s;
    assign RD_HIT  = rd_hit_s;
    assign INTR    = intr_r;

endmodule

// File: tb/tb_intr_controller.sv
// Scoreboard bench for intr_controller: expectations are queued as stimulus
// is applied and popped when the matching DUT output is sampled.
module tb_intr_controller;

    localparam logic [31:0] BASE    = 32'h1100_0060;
    localparam logic [31:0] PEND_AD = BASE + 32'h0;
    localparam logic [31:0] MASK_AD = BASE + 32'h4;
    localparam logic [31:0] ID_AD   = BASE + 32'h8;
    localparam logic [31:0] CTRL_AD = BASE + 32'hC;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [7:0]  SRC_IN = 8'h00;
    logic [31:0] IOBUS_ADDR = 32'h0;
    logic [31:0] IOBUS_OUT = 32'h0;
    logic        IOBUS_WR = 1'b0;
    logic [31:0] RD_DATA;
    logic        RD_HIT;
    logic        INTR;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];
    logic [31:0] got, exp;
    logic        hit;
    string       tag;

    intr_controller dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .SRC_IN     (SRC_IN),
        .IOBUS_ADDR (IOBUS_ADDR),
        .IOBUS_OUT  (IOBUS_OUT),
        .IOBUS_WR   (IOBUS_WR),
        .RD_DATA    (RD_DATA),
        .RD_HIT     (RD_HIT),
        .INTR       (INTR)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        IOBUS_ADDR = a;
        IOBUS_OUT  = d;
        IOBUS_WR   = 1'b1;
        tick();
        IOBUS_WR   = 1'b0;
        IOBUS_OUT  = 32'h0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic h);
        IOBUS_ADDR = a;
        #1;
        d = RD_DATA;
        h = RD_HIT;
    endtask

    task automatic expect_v(input logic [31:0] v, input string t);
        exp_q.push_back(v);
        tag_q.push_back(t);
    endtask

    // Advance until INTR is seen high or the budget runs out.
    task automatic wait_intr(input int budget, output logic seen);
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (INTR) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        tick();
        tick();
        RESET = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) expect_v(32'h0, "reset_reg");
        for (int i = 0; i < 4; i++) begin
            bus_read(BASE + 32'(i * 4), got, hit);
            exp = exp_q.pop_front(); tag = tag_q.pop_front(); vectors++;
            if (got !== exp || hit !== 1'b1) begin
                miscompares++;
                $display("FAIL %s[%0d]: got %h hit %b, expected %h hit 1", tag, i, got, hit, exp);
            end
        end
        bus_write(BASE + 32'h10, 32'hFFFF_FFFF);
        expect_v(32'h0, "unmapped_read");
        bus_read(BASE + 32'h10, got, hit);
        exp = exp_q.pop_front(); tag = tag_q.pop_front(); vectors++;
        if (got !== exp || hit !== 1'b0) begin
            miscompares++;
            $display("FAIL %s: got %h hit %b, expected %h hit 0", tag, got, hit, exp);
        end
        expect_v(32'h0, "unmapped_write_mask");
        bus_read(MASK_AD, got, hit);
        exp = exp_q.pop_front(); tag = tag_q.pop_front(); vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
        for (int i = 0; i < 20; i++) begin
            SRC_IN = 8'($urandom);
            tick();
            expect_v(32'h0, "intr_disabled");
            exp = exp_q.pop_front(); tag = tag_q.pop_front(); vectors++;
            if (32'(INTR) !== exp) begin
                miscompares++;
                $display("FAIL %s cycle %0d: got %b, expected %0d", tag, i, INTR, exp);
            end
        end
        SRC_IN = 8'h00;
        repeat (4) tick();
        bus_write(PEND_AD, 32'hFFFF_FFFF);
        expect_v(32'h0, "pend_w1c_all");
        bus_read(PEND_AD, got, hit);
        exp = exp_q.pop_front(); tag = tag_q.pop_front(); vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic test_single();
        logic seen;
        int   hi;
        bus_write(MASK_AD, 32'h0000_00FF);
        bus_write(CTRL_AD, 32'h0000_0001);
        expect_v(32'h0000_00FF, "mask_rw");
        expect_v(32'h0000_0001, "ctrl_rw");
        bus_read(MASK_AD, got, hit);
        exp = exp_q.pop_front(); tag = tag_q.pop_front(); vectors++;
        if (got !== exp) begin miscompares++; $display("FAIL %s: got %h, expected %h", tag, got, exp); end
        bus_read(CTRL_AD, got, hit);
        exp = exp_q.pop_front(); tag = tag_q.pop_front(); vectors++;
        if (got !== exp) begin miscompares++; $display("FAIL %s: got %h, expected %h", tag, got, exp); end
        SRC_IN = 8'h08;
        tick();
        tick();
        expect_v(32'h0, "pend_before_3rd_edge");
        bus_read(PEND_AD, got, hit);
        exp = exp_q.pop_front(); tag = tag_q.pop_front(); vectors++;
        if (got !== exp) begin miscompares++; $display("FAIL %s: got %h, expected %h", tag, got, exp); end
        tick();
        expect_v(32'h0000_0008, "pend_at_3rd_edge");
        bus_read(PEND_AD, got, hit);
        exp = exp_q.pop_front(); tag = tag_q.pop_front(); vectors++;
        if (got !== exp) begin miscompares++; $display("FAIL %s: got %h, expected %h", tag, got, exp); end
        wait_intr(10, seen);
        hi = 0;
        if (seen) begin
            hi = 1;
            for (int i = 0; i < 10; i++) begin
                tick();
                if (INTR) hi++;
                else break;
            end
        end
        expect_v(32'd4, "intr_width");
        exp = exp_q.pop_front(); tag = tag_q.pop_front(); vectors++;
        if (32'(hi) !== exp) begin miscompares++; $display("FAIL %s: got %0d cycles, expected %0d", tag, hi, exp); end
        expect_v(32'h8000_0003, "id_src3");
        bus_read(ID_AD, got, hit);
        exp = exp_q.pop_front(); tag = tag_q.pop_front(); vectors++;
        if (got !== exp) begin miscompares++; $display("FAIL %s: got %h, expected %h", tag, got, exp); end
        bus_write(ID_AD, 32'h0);
        expect_v(32'h0, "pend_after_claim");
        expect_v(32'h0000_0003, "id_after_claim");
        bus_read(PEND_AD, got, hit);
        exp = exp_q.pop_front(); tag = tag_q.pop_front(); vectors++;
        if (got !== exp) begin miscompares++; $display("FAIL %s: got %h, expected %h", tag, got, exp); end
        bus_read(ID_AD, got, hit);
        exp = exp_q.pop_front(); tag = tag_q.pop_front(); vectors++;
        if (got !== exp) begin miscompares++; $display("FAIL %s: got %h, expected %h", tag, got, exp); end
        for (int i = 0; i < 4; i++) begin
            expect_v(32'h0, "intr_after_claim");
            exp = exp_q.pop_front(); tag = tag_q.pop_front(); vectors++;
            if (32'(INTR) !== exp) begin miscompares++; $display("FAIL %s cycle %0d: got %b, expected %0d", tag, i, INTR, exp); end
            tick();
        end
        SRC_IN = 8'h00;
        repeat (3) tick();
    endtask

    task automatic test_priority();
        logic seen;
        int   low;
        SRC_IN = 8'h24;
        wait_intr(10, seen);
        expect_v(32'h8000_0002, "prio_first_id");
        expect_v(32'h0000_0024, "prio_pend");
        bus_read(ID_AD, got, hit);
        exp = exp_q.pop_front(); tag = tag_q.pop_front(); vectors++;
        if (got !== exp || !seen) begin miscompares++; $display("FAIL %s: got %h intr_seen %b, expected %h", tag, got, seen, exp); end
        bus_read(PEND_AD, got, hit);
        exp = exp_q.pop_front(); tag = tag_q.pop_front(); vectors++;
        if (got !== exp) begin miscompares++; $display("FAIL %s: got %h, expected %h", tag, got, exp); end
        bus_write(ID_AD, 32'h0);
        low = 0;
        while (!INTR && low < 20) begin
            low++;
            tick();
        end
        expect_v(32'h1, "cooldown_then_second");
        exp = exp_q.pop_front(); tag = tag_q.pop_front(); vectors++;
        if (32'(INTR && low >= 2) !== exp) begin miscompares++; $display("FAIL %s: low cycles %0d intr %b, expected >=2 then high", tag, low, INTR); end
        expect_v(32'h8000_0005, "prio_second_id");
        bus_read(ID_AD, got, hit);
        exp = exp_q.pop_front(); tag = tag_q.pop_front(); vectors++;
        if (got !== exp) begin miscompares++; $display("FAIL %s: got %h, expected %h", tag, got, exp); end
        bus_write(ID_AD, 32'h0);
        repeat (5) tick();
        expect_v(32'h0, "prio_pend_drained");
        bus_read(PEND_AD, got, hit);
        exp = exp_q.pop_front(); tag = tag_q.pop_front(); vectors++;
        if (got !== exp) begin miscompares++; $display("FAIL %s: got %h, expected %h", tag, got, exp); end
        SRC_IN = 8'h00;
        repeat (3) tick();
    endtask

    task automatic test_mask();
        logic seen;
        int   hi;
        bus_write(MASK_AD, 32'h0000_0001);
        SRC_IN = 8'h10;
        repeat (3) tick();
        expect_v(32'h0000_0010, "masked_pend");
        bus_read(PEND_AD, got, hit);
        exp = exp_q.pop_front(); tag = tag_q.pop_front(); vectors++;
        if (got !== exp) begin miscompares++; $display("FAIL %s: got %h, expected %h", tag, got, exp); end
        hi = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (INTR) hi++;
        end
        expect_v(32'h0, "masked_no_intr");
        exp = exp_q.pop_front(); tag = tag_q.pop_front(); vectors++;
        if (32'(hi) !== exp) begin miscompares++; $display("FAIL %s: got %0d high cycles, expected %0d", tag, hi, exp); end
        bus_write(MASK_AD, 32'h0000_0010);
        wait_intr(10, seen);
        expect_v(32'h8000_0004, "unmask_id");
        bus_read(ID_AD, got, hit);
        exp = exp_q.pop_front(); tag = tag_q.pop_front(); vectors++;
        if (got !== exp || !seen) begin miscompares++; $display("FAIL %s: got %h intr_seen %b, expected %h", tag, got, seen, exp); end
        bus_write(ID_AD, 32'h0);
        repeat (4) tick();
        SRC_IN = 8'h00;
        tick();
    endtask

    task automatic test_w1c_collision();
        SRC_IN = 8'h40;
        tick();
        tick();
        bus_write(PEND_AD, 32'h0000_0040);
        expect_v(32'h0000_0040, "set_beats_w1c");
        bus_read(PEND_AD, got, hit);
        exp = exp_q.pop_front(); tag = tag_q.pop_front(); vectors++;
        if (got !== exp) begin miscompares++; $display("FAIL %s: got %h, expected %h", tag, got, exp); end
        bus_write(PEND_AD, 32'h0000_0040);
        expect_v(32'h0, "plain_w1c");
        bus_read(PEND_AD, got, hit);
        exp = exp_q.pop_front(); tag = tag_q.pop_front(); vectors++;
        if (got !== exp) begin miscompares++; $display("FAIL %s: got %h, expected %h", tag, got, exp); end
        SRC_IN = 8'h00;
        tick();
    endtask

    task automatic test_reset_mid();
        logic seen;
        int   hi;
        bus_write(MASK_AD, 32'h0000_00FF);
        SRC_IN = 8'h02;
        wait_intr(10, seen);
        tick();
        expect_v(32'h1, "second_assert_cycle");
        exp = exp_q.pop_front(); tag = tag_q.pop_front(); vectors++;
        if (32'(INTR && seen) !== exp) begin miscompares++; $display("FAIL %s: got intr %b seen %b, expected high", tag, INTR, seen); end
        RESET = 1'b1;
        tick();
        expect_v(32'h0, "intr_after_reset");
        exp = exp_q.pop_front(); tag = tag_q.pop_front(); vectors++;
        if (32'(INTR) !== exp) begin miscompares++; $display("FAIL %s: got %b, expected %0d", tag, INTR, exp); end
        for (int i = 0; i < 4; i++) expect_v(32'h0, "reg_after_reset");
        for (int i = 0; i < 4; i++) begin
            bus_read(BASE + 32'(i * 4), got, hit);
            exp = exp_q.pop_front(); tag = tag_q.pop_front(); vectors++;
            if (got !== exp) begin miscompares++; $display("FAIL %s[%0d]: got %h, expected %h", tag, i, got, exp); end
        end
        RESET = 1'b0;
        SRC_IN = 8'h00;
        tick();
        SRC_IN = 8'h02;
        hi = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (INTR) hi++;
        end
        expect_v(32'h0, "no_intr_unconfigured");
        exp = exp_q.pop_front(); tag = tag_q.pop_front(); vectors++;
        if (32'(hi) !== exp) begin miscompares++; $display("FAIL %s: got %0d high cycles, expected %0d", tag, hi, exp); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_mask();
        test_w1c_collision();
        test_reset_mid();
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_leftover: got %0d entries, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
